// File: rtl/lt24_pkg.sv
// Shared constants, state encoding and word-selection helpers for the LT24 pixel sink.
package lt24_pkg;

  localparam int LCD_WIDTH  = 240;
  localparam int LCD_HEIGHT = 320;

  localparam logic [7:0] X_LAST = 8'(LCD_WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(LCD_HEIGHT - 1);

  localparam logic [15:0] CMD_CASET = 16'h002A;
  localparam logic [15:0] CMD_PASET = 16'h002B;
  localparam logic [15:0] CMD_RAMWR = 16'h002C;
  localparam logic [15:0] X_END     = 16'h00EF;
  localparam logic [15:0] Y_END     = 16'h013F;

  typedef enum logic [3:0] {
    IDLE, CASET, CASET_D0, CASET_D1, CASET_D2, CASET_D3,
    PASET, PASET_D0, PASET_D1, PASET_D2, PASET_D3, RAMWR, PIXEL
  } state_t;

  function automatic state_t next_state(input state_t s);
    case (s)
      CASET:    return CASET_D0;
      CASET_D0: return CASET_D1;
      CASET_D1: return CASET_D2;
      CASET_D2: return CASET_D3;
      CASET_D3: return PASET;
      PASET:    return PASET_D0;
      PASET_D0: return PASET_D1;
      PASET_D1: return PASET_D2;
      PASET_D2: return PASET_D3;
      PASET_D3: return RAMWR;
      RAMWR:    return PIXEL;
      default:  return IDLE;
    endcase
  endfunction

  // Address bytes are zero-extended; the window always closes at the panel edge.
  function automatic logic [15:0] bus_word(input state_t s, input logic [7:0] x,
                                           input logic [8:0] y, input logic [15:0] pix);
    case (s)
      CASET:    return CMD_CASET;
      CASET_D0: return 16'h0000;
      CASET_D1: return {8'h00, x};
      CASET_D2: return 16'h0000;
      CASET_D3: return X_END;
      PASET:    return CMD_PASET;
      PASET_D0: return {15'h0000, y[8]};
      PASET_D1: return {8'h00, y[7:0]};
      PASET_D2: return 16'h0001;
      PASET_D3: return Y_END;
      RAMWR:    return CMD_RAMWR;
      PIXEL:    return pix;
      default:  return 16'h0000;
    endcase
  endfunction

  function automatic logic is_command(input state_t s);
    return (s == CASET) || (s == PASET) || (s == RAMWR);
  endfunction

endpackage

// File: rtl/lt24_write_strobe.sv
// One LT24 write cycle per start pulse: Wr_n low then high for the configured counts.
// done is asserted combinationally in the final high cycle so a new start can follow back-to-back.
module lt24_write_strobe #(
  parameter int WR_LOW_CYCLES  = 1,
  parameter int WR_HIGH_CYCLES = 1
) (
  input  logic clock,
  input  logic globalReset_n,
  input  logic start,
  output logic wr_n,
  output logic done
);

  localparam int MAX_CYC = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ? WR_LOW_CYCLES : WR_HIGH_CYCLES;
  localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] LOW_LAST  = CW'(WR_LOW_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_LAST = CW'(WR_HIGH_CYCLES - 1);

  logic          busy;
  logic          low_phase;
  logic [CW-1:0] cnt;

  assign done = busy && !low_phase && (cnt == HIGH_LAST);

  always_ff @(posedge clock or negedge globalReset_n) begin
    if (!globalReset_n) begin
      wr_n      <= 1'b1;
      busy      <= 1'b0;
      low_phase <= 1'b0;
      cnt       <= '0;
    end else if (start) begin
      wr_n      <= 1'b0;
      busy      <= 1'b1;
      low_phase <= 1'b1;
      cnt       <= '0;
    end else if (busy) begin
      if (low_phase) begin
        if (cnt == LOW_LAST) begin
          wr_n      <= 1'b1;
          low_phase <= 1'b0;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (cnt == HIGH_LAST) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lt24_pixel_sink.sv
// Accepts one pixel at a time and drives the LT24 CASET/PASET/RAMWR write sequence.
// Optional STREAM_SKIP_EN: a raster-successor pixel emits only its data word.
module lt24_pixel_sink
  import lt24_pkg::*;
#(
  parameter int WR_LOW_CYCLES  = 1,
  parameter int WR_HIGH_CYCLES = 1
) (
  input  logic        clock,
  input  logic        globalReset_n,
  input  logic        enable,
  input  logic [7:0]  xAddr,
  input  logic [8:0]  yAddr,
  input  logic [15:0] pixelData,
  input  logic        pixelWrite,
  output logic        pixelReady,
  output logic        LT24Wr_n,
  output logic        LT24Rd_n,
  output logic        LT24CS_n,
  output logic        LT24RS,
  output logic [15:0] LT24Data,
  output logic        rangeError,
  output state_t      dbg_state
);

  state_t      state;
  state_t      nxt;
  logic        rdy_q;
  logic [7:0]  x_q;
  logic [8:0]  y_q;
  logic [15:0] pix_q;
  logic        accept, in_range, stream_hit, start, done;

  assign LT24Rd_n   = 1'b1;
  assign pixelReady = rdy_q & enable;
  assign dbg_state  = state;

`ifdef STREAM_SKIP_EN
  logic [7:0] last_x, succ_x;
  logic [8:0] last_y, succ_y;
  logic       last_valid, succ_ok;

  always_comb begin
    succ_ok = 1'b1;
    succ_x  = last_x + 8'd1;
    succ_y  = last_y;
    if (last_x == X_LAST) begin
      succ_x  = 8'd0;
      succ_y  = last_y + 9'd1;
      succ_ok = (last_y != Y_LAST);
    end
  end

  assign stream_hit = last_valid && succ_ok && (xAddr == succ_x) && (yAddr == succ_y);

  always_ff @(posedge clock or negedge globalReset_n) begin
    if (!globalReset_n) begin
      last_x     <= '0;
      last_y     <= '0;
      last_valid <= 1'b0;
    end else if (accept) begin
      last_x     <= xAddr;
      last_y     <= yAddr;
      last_valid <= in_range;
    end
  end
`else
  assign stream_hit = 1'b0;
`endif

  always_comb begin
    accept   = pixelWrite && pixelReady && (state == IDLE);
    in_range = (xAddr <= X_LAST) && (yAddr <= Y_LAST);
    nxt      = next_state(state);
    start    = (accept && in_range) || ((state != IDLE) && (state != PIXEL) && done);
  end

  lt24_write_strobe #(
    .WR_LOW_CYCLES (WR_LOW_CYCLES),
    .WR_HIGH_CYCLES(WR_HIGH_CYCLES)
  ) u_strobe (
    .clock        (clock),
    .globalReset_n(globalReset_n),
    .start        (start),
    .wr_n         (LT24Wr_n),
    .done         (done)
  );

  always_ff @(posedge clock or negedge globalReset_n) begin
    if (!globalReset_n) begin
      state      <= IDLE;
      rdy_q      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      pix_q      <= '0;
      LT24Data   <= '0;
      LT24RS     <= 1'b1;
      LT24CS_n   <= 1'b1;
      rangeError <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        rdy_q <= 1'b0;
        x_q   <= xAddr;
        y_q   <= yAddr;
        pix_q <= pixelData;
        if (!in_range) begin
          rangeError <= 1'b1;
        end else if (stream_hit) begin
          state    <= PIXEL;
          LT24Data <= pixelData;
          LT24RS   <= 1'b1;
          LT24CS_n <= 1'b0;
        end else begin
          state    <= CASET;
          LT24Data <= CMD_CASET;
          LT24RS   <= 1'b0;
          LT24CS_n <= 1'b0;
        end
      end else begin
        rdy_q <= enable;
      end
    end else if (done) begin
      // Next word is loaded on the same edge the strobe restarts, keeping data stable per write.
      if (state == PIXEL) begin
        state    <= IDLE;
        LT24CS_n <= 1'b1;
        rdy_q    <= enable;
      end else begin
        state    <= nxt;
        LT24Data <= bus_word(nxt, x_q, y_q, pix_q);
        LT24RS   <= !is_command(nxt);
      end
    end
  end

endmodule

// File: tb/tb_lt24_pixel_sink.sv
// Directed bench for lt24_pixel_sink; expectations follow STREAM_SKIP_EN when it is defined.
module tb_lt24_pixel_sink;
  import lt24_pkg::*;

  logic        clock = 1'b0;
  logic        globalReset_n = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  xAddr = '0;
  logic [8:0]  yAddr = '0;
  logic [15:0] pixelData = '0;
  logic        pixelWrite = 1'b0;
  logic        pixelReady, LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, rangeError;
  logic [15:0] LT24Data;
  state_t      dbg_state;

  int checks = 0;
  int failures = 0;
  int falls = 0;
  int cs_bad = 0;
  int rd_bad = 0;
  logic prev_wr = 1'b1;
  logic [16:0] exp_q[$];
  logic [16:0] obs_q[$];

  lt24_pixel_sink dut (
    .clock(clock), .globalReset_n(globalReset_n), .enable(enable),
    .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData), .pixelWrite(pixelWrite),
    .pixelReady(pixelReady), .LT24Wr_n(LT24Wr_n), .LT24Rd_n(LT24Rd_n),
    .LT24CS_n(LT24CS_n), .LT24RS(LT24RS), .LT24Data(LT24Data),
    .rangeError(rangeError), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (prev_wr === 1'b1 && LT24Wr_n === 1'b0) begin
      obs_q.push_back({LT24RS, LT24Data});
      falls++;
    end
    if (LT24Wr_n === 1'b0 && LT24CS_n !== 1'b0) cs_bad++;
    if (LT24Rd_n !== 1'b1) rd_bad++;
    prev_wr = LT24Wr_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_full(input logic [7:0] x, input logic [8:0] y, input logic [15:0] d);
    exp_q.push_back({1'b0, 16'h002A});
    exp_q.push_back({1'b1, 16'h0000});
    exp_q.push_back({1'b1, 8'h00, x});
    exp_q.push_back({1'b1, 16'h0000});
    exp_q.push_back({1'b1, 16'h00EF});
    exp_q.push_back({1'b0, 16'h002B});
    exp_q.push_back({1'b1, 15'h0000, y[8]});
    exp_q.push_back({1'b1, 8'h00, y[7:0]});
    exp_q.push_back({1'b1, 16'h0001});
    exp_q.push_back({1'b1, 16'h013F});
    exp_q.push_back({1'b0, 16'h002C});
    exp_q.push_back({1'b1, d});
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  // Called at a negedge; returns at the negedge where pixelReady is seen high again.
  // lat counts clock edges from the accept edge to the edge that raised pixelReady.
  task automatic send_pixel(input logic [7:0] x, input logic [8:0] y, input logic [15:0] d,
                            input bit hold, output int lat);
    int k;
    k = 0;
    while (pixelReady !== 1'b1 && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk("ready_before_send", pixelReady, 1);
    xAddr = x;
    yAddr = y;
    pixelData = d;
    pixelWrite = 1'b1;
    @(posedge clock);
    #1;
    if (!hold) pixelWrite = 1'b0;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (pixelReady !== 1'b1 && k < 200);
    pixelWrite = 1'b0;
    lat = k - 1;
  endtask

  initial begin
    int lat;
    int f0;

    // reset
    #1 globalReset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_wr_n", LT24Wr_n, 1);
    chk("rst_rd_n", LT24Rd_n, 1);
    chk("rst_cs_n", LT24CS_n, 1);
    chk("rst_rs", LT24RS, 1);
    chk("rst_data", LT24Data, 0);
    chk("rst_ready", pixelReady, 0);
    chk("rst_range_err", rangeError, 0);
    chk("rst_state", dbg_state, IDLE);
    enable = 1'b1;
    globalReset_n = 1'b1;
    chk("ready_not_at_release", pixelReady, 0);
    @(negedge clock);
    chk("ready_after_release", pixelReady, 1);
    obs_q.delete();
    falls = 0;

    // basic full sequence with pixelWrite held high
    push_full(8'd10, 9'd20, 16'hF800);
    send_pixel(8'd10, 9'd20, 16'hF800, 1'b1, lat);
    chk("basic_latency", lat, 24);
    check_words("basic");
    chk("basic_cs_idle", LT24CS_n, 1);
    chk("basic_no_requeue", dbg_state, IDLE);

    // row wrap (239,5) -> (0,6)
    push_full(8'd239, 9'd5, 16'h1234);
    send_pixel(8'd239, 9'd5, 16'h1234, 1'b0, lat);
    chk("wrap_a_latency", lat, 24);
    check_words("wrap_a");
`ifdef STREAM_SKIP_EN
    exp_q.push_back({1'b1, 16'h5678});
    send_pixel(8'd0, 9'd6, 16'h5678, 1'b0, lat);
    chk("wrap_b_latency", lat, 2);
`else
    push_full(8'd0, 9'd6, 16'h5678);
    send_pixel(8'd0, 9'd6, 16'h5678, 1'b0, lat);
    chk("wrap_b_latency", lat, 24);
`endif
    check_words("wrap_b");

    // last pixel has no successor
    push_full(8'd239, 9'd319, 16'hAAAA);
    send_pixel(8'd239, 9'd319, 16'hAAAA, 1'b0, lat);
    check_words("corner_a");
    push_full(8'd0, 9'd0, 16'h5555);
    send_pixel(8'd0, 9'd0, 16'h5555, 1'b0, lat);
    chk("corner_b_latency", lat, 24);
    check_words("corner_b");

    // out-of-range pixel, then successor-looking pixel still needs full sequence
    f0 = falls;
    send_pixel(8'd240, 9'd0, 16'hFFFF, 1'b0, lat);
    chk("range_latency", lat, 1);
    chk("range_no_writes", falls - f0, 0);
    chk("range_err_set", rangeError, 1);
    push_full(8'd0, 9'd0, 16'h0F0F);
    send_pixel(8'd0, 9'd0, 16'h0F0F, 1'b0, lat);
    chk("after_range_latency", lat, 24);
    check_words("after_range");
    f0 = falls;
    send_pixel(8'd0, 9'd320, 16'h0001, 1'b0, lat);
    chk("range_y_no_writes", falls - f0, 0);
    obs_q.delete();

    // reset at cycle 7 of a sequence
    xAddr = 8'd0; yAddr = 9'd0; pixelData = 16'h4321; pixelWrite = 1'b1;
    @(posedge clock);
    #1 pixelWrite = 1'b0;
    repeat (7) @(negedge clock);
    globalReset_n = 1'b0;
    #1;
    chk("midrst_wr_n", LT24Wr_n, 1);
    chk("midrst_cs_n", LT24CS_n, 1);
    chk("midrst_ready", pixelReady, 0);
    chk("midrst_range_err", rangeError, 0);
    f0 = falls;
    repeat (4) @(negedge clock);
    chk("midrst_no_strobes", falls - f0, 0);
    globalReset_n = 1'b1;
    obs_q.delete();
    @(negedge clock);
    push_full(8'd1, 9'd0, 16'h00FF);
    send_pixel(8'd1, 9'd0, 16'h00FF, 1'b0, lat);
    chk("postrst_latency", lat, 24);
    check_words("postrst");

    // enable low blocks acceptance
    enable = 1'b0;
    pixelWrite = 1'b1;
    xAddr = 8'd50; yAddr = 9'd60; pixelData = 16'h07E0;
    f0 = falls;
    repeat (5) begin
      @(negedge clock);
      chk("disabled_ready", pixelReady, 0);
    end
    chk("disabled_no_writes", falls - f0, 0);
    enable = 1'b1;
    @(negedge clock);
    chk("enable_ready", pixelReady, 1);
    @(posedge clock);
    #1 pixelWrite = 1'b0;
    chk("enable_accept", dbg_state, CASET);
    push_full(8'd50, 9'd60, 16'h07E0);
    repeat (30) @(negedge clock);
    check_words("enable_seq");

    // enable drops mid-sequence: sequence completes, ready held low
    push_full(8'd100, 9'd200, 16'h001F);
    xAddr = 8'd100; yAddr = 9'd200; pixelData = 16'h001F; pixelWrite = 1'b1;
    @(posedge clock);
    #1 pixelWrite = 1'b0;
    repeat (5) @(negedge clock);
    enable = 1'b0;
    repeat (30) @(negedge clock);
    check_words("drop_seq");
    chk("drop_ready_low", pixelReady, 0);
    chk("drop_cs_idle", LT24CS_n, 1);
    enable = 1'b1;
    @(negedge clock);
    chk("drop_ready_back", pixelReady, 1);

    chk("cs_low_during_writes", cs_bad, 0);
    chk("rd_n_constant", rd_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
